// File: rtl/sprite_pixel_fetch_if.sv
// sprite_pixel_fetch_if: pixel stream, position handshake, ROM port and colour output of the sprite fetcher
//   pix_x/pix_y/pix_valid  pixel coordinates and active-area strobe
//   frame_start            one-cycle pulse at the first cycle of a frame
//   pos_x_in/pos_y_in      requested sprite top-left, pos_req level request, pos_ack apply pulse
//   hflip_in               requested horizontal flip (only with SPRITE_HFLIP_EN)
//   rom_line/rom_offset    registered ROM address, rom_bit combinational ROM data
//   rgb_out/rgb_valid      pixel colour two clocks after the pixel
interface sprite_pixel_fetch_if;
   logic [9:0]  pix_x, pix_y;
   logic        pix_valid, frame_start;
   logic [9:0]  pos_x_in, pos_y_in;
   logic        pos_req, pos_ack;
`ifdef SPRITE_HFLIP_EN
   logic        hflip_in;
`endif
   logic [6:0]  rom_line, rom_offset;
   logic        rom_bit;
   logic [11:0] rgb_out;
   logic        rgb_valid;
   modport slave (
      input  pix_x, pix_y, pix_valid, frame_start, pos_x_in, pos_y_in, pos_req,
`ifdef SPRITE_HFLIP_EN
      input  hflip_in,
`endif
      input  rom_bit,
      output pos_ack, rom_line, rom_offset, rgb_out, rgb_valid
   );
   modport master (
      output pix_x, pix_y, pix_valid, frame_start, pos_x_in, pos_y_in, pos_req,
`ifdef SPRITE_HFLIP_EN
      output hflip_in,
`endif
      output rom_bit,
      input  pos_ack, rom_line, rom_offset, rgb_out, rgb_valid
   );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: maps VGA pixels into the sprite box, fetches the ROM bit and emits a 2-cycle-latency colour
//   clk     pixel clock
//   resetn  asynchronous active-low reset
//   bus     sprite_pixel_fetch_if.slave (pixel stream, position req/ack, ROM port, rgb output)
//   SPRITE_HFLIP_EN  optional macro: adds bus.hflip_in, mirroring rom_offset when the applied flip is set
module sprite_pixel_fetch #(
   parameter logic [6:0]  SPR_W  = 7'd127,
   parameter logic [6:0]  SPR_H  = 7'd32,
   parameter logic [11:0] FG_RGB = 12'hFFF,
   parameter logic [11:0] BG_RGB = 12'h000
) (
   input logic clk,
   input logic resetn,
   sprite_pixel_fetch_if.slave bus
);
   typedef enum logic {IDLE, PEND} state_t;
   state_t      state, state_d;
   logic [9:0]  pos_x, pos_y, pend_x, pend_y, pend_x_d, pend_y_d;
   logic        apply;
   logic [10:0] dx, dy;
   logic        hit, hit_q, vld_q;
   logic [6:0]  off;
`ifdef SPRITE_HFLIP_EN
   logic        flip, pend_f, pend_f_d;
`endif
   // the same-cycle request is folded into the pending value so PEND+frame_start+pos_req applies the newest position
   always_comb begin
      pend_x_d = bus.pos_req ? bus.pos_x_in : pend_x;
      pend_y_d = bus.pos_req ? bus.pos_y_in : pend_y;
`ifdef SPRITE_HFLIP_EN
      pend_f_d = bus.pos_req ? bus.hflip_in : pend_f;
`endif
      apply = (state == PEND) && bus.frame_start;
      state_d = apply ? IDLE : (bus.pos_req ? PEND : state);
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_d;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_x <= '0;
         pend_y <= '0;
         pos_x <= '0;
         pos_y <= '0;
         bus.pos_ack <= 1'b0;
`ifdef SPRITE_HFLIP_EN
         pend_f <= 1'b0;
         flip <= 1'b0;
`endif
      end else begin
         pend_x <= pend_x_d;
         pend_y <= pend_y_d;
         bus.pos_ack <= apply;
         if (apply) begin
            pos_x <= pend_x_d;
            pos_y <= pend_y_d;
         end
`ifdef SPRITE_HFLIP_EN
         pend_f <= pend_f_d;
         if (apply) flip <= pend_f_d;
`endif
      end
   end
   // 11-bit differences; the explicit >= tests keep an off-screen position from wrapping into a hit
   assign dx = {1'b0, bus.pix_x} - {1'b0, pos_x};
   assign dy = {1'b0, bus.pix_y} - {1'b0, pos_y};
   assign hit = bus.pix_valid && (bus.pix_x >= pos_x) && (bus.pix_y >= pos_y) &&
                (dx <= {4'd0, SPR_W}) && (dy < {4'd0, SPR_H});
`ifdef SPRITE_HFLIP_EN
   assign off = flip ? SPR_W - dx[6:0] : dx[6:0];
`else
   assign off = dx[6:0];
`endif
   // a miss parks the ROM on line 7F so it reads 0; hit_q still gates the colour
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_q <= 1'b0;
         vld_q <= 1'b0;
         bus.rom_line <= 7'h7F;
         bus.rom_offset <= 7'd0;
         bus.rgb_out <= BG_RGB;
         bus.rgb_valid <= 1'b0;
      end else begin
         hit_q <= hit;
         vld_q <= bus.pix_valid;
         bus.rom_line <= hit ? dy[6:0] : 7'h7F;
         bus.rom_offset <= hit ? off : 7'd0;
         bus.rgb_out <= (hit_q && bus.rom_bit) ? FG_RGB : BG_RGB;
         bus.rgb_valid <= vld_q;
      end
   end
endmodule
